hood_mode_ctrl: RTL and testbench

Parametrised mode controller for the kitchen-hood design, the next generation of the fixed five-mode selector.

- Supports any number of fan levels. The top level is a timed, once-per-power-cycle hurricane level.
- Adds a menu-delayed exit from hurricane and a timed self-clean, both driven by an internal 1 s prescaler.
- Sits between the debounced button/power logic and the fan, LED and display blocks.
- Outputs registered mode, fan level and countdown seconds for the display driver.

---
 rtl/hood_mode_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_hood_mode_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/hood_mode_ctrl.sv
// hood_mode_ctrl: mode controller for the kitchen hood. It takes debounced
// button pulses and the power level, and drives registered mode, fan level,
// countdown seconds and the LEDs. A free-running prescaler divides clk into
// 1 s ticks. The ticks pace the hurricane, hurricane-exit and self-clean timers.
module hood_mode_ctrl #(
    parameter int CLK_HZ        = 100_000_000,
    parameter int NUM_LEVELS    = 3,
    parameter int HURRICANE_SEC = 60,
    parameter int EXIT_SEC      = 60,
    parameter int CLEAN_SEC     = 180,
    parameter int CD_W          = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              power_on,
    input  logic                              menu_btn,
    input  logic [NUM_LEVELS-1:0]             level_btn,
    input  logic                              clean_btn,
    output logic [2:0]                        mode_state,
    output logic [$clog2(NUM_LEVELS+1)-1:0]   fan_level,
    output logic [CD_W-1:0]                   countdown,
    output logic [NUM_LEVELS-1:0]             level_led,
    output logic                              clean_led,
    output logic                              clean_done
);

    localparam int FW = $clog2(NUM_LEVELS + 1);
    localparam int PW = $clog2(CLK_HZ);

    localparam logic [PW-1:0]   PRESC_MAX = PW'(CLK_HZ - 1);
    localparam logic [FW-1:0]   TOP_LVL   = FW'(NUM_LEVELS);
    localparam logic [FW-1:0]   TOP_IDX   = FW'(NUM_LEVELS - 1);
    localparam logic [FW-1:0]   HI_LVL    = FW'(NUM_LEVELS - 1);
    localparam logic [CD_W-1:0] HURRI_CD  = CD_W'(HURRICANE_SEC);
    localparam logic [CD_W-1:0] EXIT_CD   = CD_W'(EXIT_SEC);
    localparam logic [CD_W-1:0] CLEAN_CD  = CD_W'(CLEAN_SEC);

    typedef enum logic [2:0] {
        ST_OFF        = 3'd0,
        ST_STANDBY    = 3'd1,
        ST_MENU       = 3'd2,
        ST_LEVEL      = 3'd3,
        ST_HURRI      = 3'd4,
        ST_HURRI_EXIT = 3'd5,
        ST_CLEAN      = 3'd6
    } state_t;

    state_t                 state_q, state_d;
    logic [FW-1:0]          fan_q, fan_d;
    logic [CD_W-1:0]        cd_q, cd_d;
    logic [PW-1:0]          presc_q, presc_d;
    logic                   hurri_used_q, hurri_used_d;
    logic                   clean_done_q, clean_done_d;
    logic [NUM_LEVELS-1:0]  level_led_q, level_led_d;
    logic                   clean_led_q, clean_led_d;

    logic                   any_req;
    logic [FW-1:0]          any_sel;
    logic                   low_req;
    logic [FW-1:0]          low_sel;
    logic                   tick;
    logic                   expire;

    assign tick   = (presc_q == PRESC_MAX);
    assign expire = tick && (cd_q == CD_W'(1));

    // Lowest set level request among all bits, and among the non-hurricane bits
    always_comb begin
        any_req = 1'b0;
        any_sel = '0;
        low_req = 1'b0;
        low_sel = '0;
        for (int i = NUM_LEVELS - 1; i >= 0; i--) begin
            if (level_btn[i]) begin
                any_req = 1'b1;
                any_sel = FW'(i);
            end
        end
        for (int i = NUM_LEVELS - 2; i >= 0; i--) begin
            if (level_btn[i]) begin
                low_req = 1'b1;
                low_sel = FW'(i);
            end
        end
    end

    // Next-state, fan level, countdown and hurricane one-shot flag
    always_comb begin
        state_d      = state_q;
        fan_d        = fan_q;
        cd_d         = cd_q;
        hurri_used_d = hurri_used_q;
        clean_done_d = 1'b0;

        if (!power_on) begin
            state_d      = ST_OFF;
            fan_d        = '0;
            cd_d         = '0;
            hurri_used_d = 1'b0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d = ST_STANDBY;
                    fan_d   = '0;
                    cd_d    = '0;
                end
                ST_STANDBY: begin
                    if (menu_btn) begin
                        state_d = ST_MENU;
                    end
                end
                ST_MENU: begin
                    if (menu_btn) begin
                        state_d = ST_STANDBY;
                    end else if (clean_btn) begin
                        state_d = ST_CLEAN;
                        fan_d   = '0;
                        cd_d    = CLEAN_CD;
                    end else if (any_req) begin
                        if (any_sel == TOP_IDX) begin
                            // Hurricane is once per power cycle; a repeat request is dropped
                            if (!hurri_used_q) begin
                                state_d      = ST_HURRI;
                                fan_d        = TOP_LVL;
                                cd_d         = HURRI_CD;
                                hurri_used_d = 1'b1;
                            end
                        end else begin
                            state_d = ST_LEVEL;
                            fan_d   = any_sel + FW'(1);
                        end
                    end
                end
                ST_LEVEL: begin
                    if (menu_btn) begin
                        state_d = ST_STANDBY;
                        fan_d   = '0;
                    end else if (low_req) begin
                        fan_d = low_sel + FW'(1);
                    end
                end
                ST_HURRI: begin
                    // Timer expiry wins over a menu press landing on the same cycle
                    if (expire) begin
                        state_d = ST_LEVEL;
                        fan_d   = HI_LVL;
                        cd_d    = '0;
                    end else if (menu_btn) begin
                        state_d = ST_HURRI_EXIT;
                        cd_d    = EXIT_CD;
                    end else if (tick) begin
                        cd_d = cd_q - CD_W'(1);
                    end
                end
                ST_HURRI_EXIT: begin
                    if (expire) begin
                        state_d = ST_STANDBY;
                        fan_d   = '0;
                        cd_d    = '0;
                    end else if (tick) begin
                        cd_d = cd_q - CD_W'(1);
                    end
                end
                ST_CLEAN: begin
                    if (expire) begin
                        state_d      = ST_STANDBY;
                        cd_d         = '0;
                        clean_done_d = 1'b1;
                    end else if (tick) begin
                        cd_d = cd_q - CD_W'(1);
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    fan_d   = '0;
                    cd_d    = '0;
                end
            endcase
        end
    end

    // Prescaler restarts on every state change so each timed state dwells whole seconds
    always_comb begin
        presc_d = presc_q + PW'(1);
        if ((state_d != state_q) || tick) begin
            presc_d = '0;
        end
    end

    // LEDs are derived from the next values so they stay aligned with fan/mode
    generate
        for (genvar gi = 0; gi < NUM_LEVELS; gi++) begin : g_led
            assign level_led_d[gi] = (fan_d == FW'(gi + 1));
        end
    endgenerate
    assign clean_led_d = (state_d == ST_CLEAN);

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_OFF;
            fan_q        <= '0;
            cd_q         <= '0;
            presc_q      <= '0;
            hurri_used_q <= 1'b0;
            clean_done_q <= 1'b0;
            level_led_q  <= '0;
            clean_led_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            fan_q        <= fan_d;
            cd_q         <= cd_d;
            presc_q      <= presc_d;
            hurri_used_q <= hurri_used_d;
            clean_done_q <= clean_done_d;
            level_led_q  <= level_led_d;
            clean_led_q  <= clean_led_d;
        end
    end

    assign mode_state = state_q;
    assign fan_level  = fan_q;
    assign countdown  = cd_q;
    assign level_led  = level_led_q;
    assign clean_led  = clean_led_q;
    assign clean_done = clean_done_q;

endmodule

// File: tb/tb_hood_mode_ctrl.sv
// Testbench for hood_mode_ctrl. The driver pushes the expected registered
// outputs for each cycle into a queue. A monitor pops each entry one time unit
// after the clock edge and compares it against the DUT.
`timescale 1ns/1ps
module tb_hood_mode_ctrl;

    localparam logic [2:0] M_OFF   = 3'd0;
    localparam logic [2:0] M_STBY  = 3'd1;
    localparam logic [2:0] M_MENU  = 3'd2;
    localparam logic [2:0] M_LEVEL = 3'd3;
    localparam logic [2:0] M_HURRI = 3'd4;
    localparam logic [2:0] M_HEXIT = 3'd5;
    localparam logic [2:0] M_CLEAN = 3'd6;

    logic       clk = 1'b0;
    logic       rst;
    logic       power_on;
    logic       menu_btn;
    logic [2:0] level_btn;
    logic       clean_btn;
    logic [2:0] mode_state;
    logic [1:0] fan_level;
    logic [7:0] countdown;
    logic [2:0] level_led;
    logic       clean_led;
    logic       clean_done;

    int n_cmp = 0;
    int n_err = 0;

    logic [17:0] exp_q[$];
    string       tag_q[$];

    hood_mode_ctrl #(
        .CLK_HZ(4), .NUM_LEVELS(3), .HURRICANE_SEC(3),
        .EXIT_SEC(2), .CLEAN_SEC(5), .CD_W(8)
    ) dut (
        .clk(clk), .rst(rst), .power_on(power_on), .menu_btn(menu_btn),
        .level_btn(level_btn), .clean_btn(clean_btn), .mode_state(mode_state),
        .fan_level(fan_level), .countdown(countdown), .level_led(level_led),
        .clean_led(clean_led), .clean_done(clean_done)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got mode/fan/cd/led/cl/done=%h, expected %h", tag, obs, exp);
        end
    endtask

    // Expected output word: {mode, fan, countdown, level_led, clean_led, clean_done}
    function automatic logic [17:0] pack_exp(input logic [2:0] m, input logic [1:0] f,
                                             input logic [7:0] c, input logic d);
        logic [2:0] led;
        led = 3'b000;
        if (f != 2'd0) led[f - 2'd1] = 1'b1;
        return {m, f, c, led, (m == M_CLEAN), d};
    endfunction

    // Drive one cycle of inputs and queue the outputs expected after the next edge
    task automatic cyc(input logic m, input logic [2:0] lv, input logic cb,
                       input logic pw, input logic r,
                       input logic [2:0] em, input logic [1:0] ef,
                       input logic [7:0] ec, input logic ed, input string tag);
        @(negedge clk);
        menu_btn  = m;
        level_btn = lv;
        clean_btn = cb;
        power_on  = pw;
        rst       = r;
        exp_q.push_back(pack_exp(em, ef, ec, ed));
        tag_q.push_back(tag);
        @(posedge clk);
    endtask

    task automatic idle(input logic [2:0] em, input logic [1:0] ef,
                        input logic [7:0] ec, input logic ed, input string tag);
        cyc(1'b0, 3'b000, 1'b0, 1'b1, 1'b1, em, ef, ec, ed, tag);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            chk_val(tag_q.pop_front(),
                    {mode_state, fan_level, countdown, level_led, clean_led, clean_done},
                    exp_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; power_on = 1'b1; menu_btn = 1'b0; level_btn = 3'b000; clean_btn = 1'b0;

        // Reset held three cycles, then power-up
        for (int i = 0; i < 3; i++) cyc(0, 3'b000, 0, 1, 0, M_OFF, 2'd0, 8'd0, 0, "reset");
        cyc(0, 3'b000, 0, 1, 1, M_STBY, 2'd0, 8'd0, 0, "power_up");
        cyc(0, 3'b001, 1, 1, 1, M_STBY, 2'd0, 8'd0, 0, "stby_ignore");

        // Level select
        cyc(1, 3'b000, 0, 1, 1, M_MENU,  2'd0, 8'd0, 0, "lvl_menu");
        cyc(0, 3'b001, 0, 1, 1, M_LEVEL, 2'd1, 8'd0, 0, "lvl_1");
        cyc(0, 3'b010, 0, 1, 1, M_LEVEL, 2'd2, 8'd0, 0, "lvl_2");
        cyc(0, 3'b100, 0, 1, 1, M_LEVEL, 2'd2, 8'd0, 0, "lvl_top_ign");
        cyc(0, 3'b000, 1, 1, 1, M_LEVEL, 2'd2, 8'd0, 0, "lvl_clean_ign");
        cyc(0, 3'b101, 0, 1, 1, M_LEVEL, 2'd1, 8'd0, 0, "lvl_low_of_101");
        cyc(1, 3'b000, 0, 1, 1, M_STBY,  2'd0, 8'd0, 0, "lvl_exit");

        // Hurricane expiry after 12 cycles, then one-shot lockout
        cyc(1, 3'b000, 0, 1, 1, M_MENU,  2'd0, 8'd0, 0, "hur_menu");
        cyc(0, 3'b100, 0, 1, 1, M_HURRI, 2'd3, 8'd3, 0, "hur_enter");
        for (int k = 1; k < 12; k++) idle(M_HURRI, 2'd3, 8'(3 - k / 4), 0, "hur_cd");
        idle(M_LEVEL, 2'd2, 8'd0, 0, "hur_expire");
        cyc(1, 3'b000, 0, 1, 1, M_STBY, 2'd0, 8'd0, 0, "hur_stby");
        cyc(1, 3'b000, 0, 1, 1, M_MENU, 2'd0, 8'd0, 0, "hur_menu2");
        cyc(0, 3'b100, 0, 1, 1, M_MENU, 2'd0, 8'd0, 0, "hur_oneshot");
        cyc(1, 3'b000, 0, 1, 1, M_STBY, 2'd0, 8'd0, 0, "hur_back");

        // Power cycle re-arms hurricane; menu press 5 cycles in starts the exit delay
        cyc(0, 3'b000, 0, 0, 1, M_OFF,   2'd0, 8'd0, 0, "hx_pwr_off");
        cyc(0, 3'b000, 0, 1, 1, M_STBY,  2'd0, 8'd0, 0, "hx_pwr_on");
        cyc(1, 3'b000, 0, 1, 1, M_MENU,  2'd0, 8'd0, 0, "hx_menu");
        cyc(0, 3'b100, 0, 1, 1, M_HURRI, 2'd3, 8'd3, 0, "hx_enter");
        for (int k = 1; k < 5; k++) idle(M_HURRI, 2'd3, 8'(3 - k / 4), 0, "hx_hurri_cd");
        cyc(1, 3'b000, 0, 1, 1, M_HEXIT, 2'd3, 8'd2, 0, "hx_exit_enter");
        for (int j = 1; j < 8; j++) idle(M_HEXIT, 2'd3, 8'(2 - j / 4), 0, "hx_exit_cd");
        idle(M_STBY, 2'd0, 8'd0, 0, "hx_stby");

        // Self-clean runs 20 cycles, ignoring buttons, then pulses clean_done
        cyc(1, 3'b000, 0, 1, 1, M_MENU,  2'd0, 8'd0, 0, "cl_menu");
        cyc(0, 3'b000, 1, 1, 1, M_CLEAN, 2'd0, 8'd5, 0, "cl_enter");
        for (int k = 1; k < 20; k++) begin
            cyc(k == 2, (k == 5) ? 3'b001 : ((k == 13) ? 3'b100 : 3'b000), k == 9, 1, 1,
                M_CLEAN, 2'd0, 8'(5 - k / 4), 0, "cl_cd");
        end
        idle(M_STBY, 2'd0, 8'd0, 1, "cl_done");
        idle(M_STBY, 2'd0, 8'd0, 0, "cl_done_drop");

        // Power drop aborts clean without clean_done
        cyc(1, 3'b000, 0, 1, 1, M_MENU,  2'd0, 8'd0, 0, "ab_menu");
        cyc(0, 3'b000, 1, 1, 1, M_CLEAN, 2'd0, 8'd5, 0, "ab_enter");
        for (int k = 1; k < 7; k++) idle(M_CLEAN, 2'd0, 8'(5 - k / 4), 0, "ab_cd");
        cyc(0, 3'b000, 0, 0, 1, M_OFF,  2'd0, 8'd0, 0, "ab_off");
        cyc(0, 3'b000, 0, 0, 1, M_OFF,  2'd0, 8'd0, 0, "ab_off_hold");
        cyc(0, 3'b000, 0, 1, 1, M_STBY, 2'd0, 8'd0, 0, "ab_on");

        // MENU priority resolution
        cyc(1, 3'b000, 0, 1, 1, M_MENU,  2'd0, 8'd0, 0, "pr_menu");
        cyc(1, 3'b011, 1, 1, 1, M_STBY,  2'd0, 8'd0, 0, "pr_menu_wins");
        cyc(1, 3'b000, 0, 1, 1, M_MENU,  2'd0, 8'd0, 0, "pr_menu2");
        cyc(0, 3'b011, 1, 1, 1, M_CLEAN, 2'd0, 8'd5, 0, "pr_clean_wins");
        cyc(0, 3'b000, 0, 0, 1, M_OFF,   2'd0, 8'd0, 0, "pr_off");
        cyc(0, 3'b000, 0, 1, 1, M_STBY,  2'd0, 8'd0, 0, "pr_on");
        cyc(1, 3'b000, 0, 1, 1, M_MENU,  2'd0, 8'd0, 0, "pr_menu3");
        cyc(0, 3'b110, 0, 1, 1, M_LEVEL, 2'd2, 8'd0, 0, "pr_lowest_bit");
        cyc(1, 3'b000, 0, 1, 1, M_STBY,  2'd0, 8'd0, 0, "pr_exit");

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
